// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the EX-stage multi-cycle mul/div unit:
// data width, M-extension funct3 encodings, sequencer states and op helpers.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_CALC  = 3'd2,
      ST_FIXUP = 3'd3,
      ST_DONE  = 3'd4
   } muldiv_state_e;

   function automatic logic op_is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

   // rs1 is treated as signed for DIV, REM, MULH and MULHSU
   function automatic logic op_signed_a(input logic [2:0] f3);
      return (f3 == OP_DIV) || (f3 == OP_REM) ||
             (f3 == OP_MULH) || (f3 == OP_MULHSU);
   endfunction

   // rs2 is treated as signed for DIV, REM and MULH
   function automatic logic op_signed_b(input logic [2:0] f3);
      return (f3 == OP_DIV) || (f3 == OP_REM) || (f3 == OP_MULH);
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand, product, remainder and quotient registers of the mul/div unit.
// Ports: clk_i/rst_i; strobes load_i (latch op), init_i (seed working regs),
// step_i (one iteration), special_ld_i / fixup_i (load result_o);
// funct3_i, operand_a_i, operand_b_i; special_o flags divide special cases.
module muldiv_datapath
   import riscv_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            init_i,
   input  logic            step_i,
   input  logic            special_ld_i,
   input  logic            fixup_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] operand_a_i,
   input  logic [XLEN-1:0] operand_b_i,
   output logic            special_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [2:0]        op_q;
   logic [XLEN-1:0]   a_q, b_q;
   logic [XLEN-1:0]   mag_a_q, mag_b_q;
   logic              sa_q, neg_q;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic [XLEN:0]     rem_q, rem_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   res_q, res_d;

   logic              sa_in, sb_in;
   logic [XLEN-1:0]   mag_a_in, mag_b_in;

   always_comb begin
      sa_in    = op_signed_a(funct3_i) & operand_a_i[XLEN-1];
      sb_in    = op_signed_b(funct3_i) & operand_b_i[XLEN-1];
      mag_a_in = sa_in ? -operand_a_i : operand_a_i;
      mag_b_in = sb_in ? -operand_b_i : operand_b_i;
   end

   // Divide special cases are decided on the raw latched operands
   logic            is_div, div0, ovf;
   logic [XLEN-1:0] spec_res;

   always_comb begin
      is_div   = op_is_div(op_q);
      div0     = (b_q == '0);
      ovf      = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                 (a_q == INT_MIN) && (b_q == '1);
      special_o = is_div & (div0 | ovf);
      spec_res = '0;
      if (div0)
         spec_res = op_q[1] ? a_q : '1;
      else if (ovf)
         spec_res = op_q[1] ? '0 : INT_MIN;
   end

   // Shift-add multiply: low half starts as the multiplier and is shifted
   // out as the partial sum is shifted in from the top.
   logic [XLEN:0] madd;
   // Restoring divide: a non-negative trial difference keeps the subtract.
   logic [XLEN:0] shifted, diff;

   always_comb begin
      madd    = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                (prod_q[0] ? {1'b0, mag_a_q} : '0);
      shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
      diff    = shifted - {1'b0, mag_b_q};
      prod_d  = prod_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      if (init_i) begin
         prod_d = {{XLEN{1'b0}}, mag_b_q};
         rem_d  = '0;
         quo_d  = mag_a_q;
      end else if (step_i) begin
         if (is_div) begin
            rem_d = diff[XLEN] ? shifted : diff;
            quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
         end else begin
            prod_d = {madd, prod_q[XLEN-1:1]};
         end
      end
   end

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fix_res;

   always_comb begin
      prod_s = neg_q ? -prod_q : prod_q;
      quo_s  = neg_q ? -quo_q : quo_q;
      rem_s  = sa_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
      if (is_div)
         fix_res = op_q[1] ? rem_s : quo_s;
      else if (op_q == OP_MUL)
         fix_res = prod_s[XLEN-1:0];
      else
         fix_res = prod_s[2*XLEN-1:XLEN];
      res_d = res_q;
      if (special_ld_i)
         res_d = spec_res;
      else if (fixup_i)
         res_d = fix_res;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mag_a_q <= '0;
         mag_b_q <= '0;
         sa_q    <= 1'b0;
         neg_q   <= 1'b0;
         prod_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
      end else begin
         if (load_i) begin
            op_q    <= funct3_i;
            a_q     <= operand_a_i;
            b_q     <= operand_b_i;
            mag_a_q <= mag_a_in;
            mag_b_q <= mag_b_in;
            sa_q    <= sa_in;
            neg_q   <= sa_in ^ sb_in;
         end
         prod_q <= prod_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         res_q  <= res_d;
      end
   end

   assign result_o = res_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: FSM that stalls the pipeline while the
// datapath iterates XLEN times. Ports: clk_i, rst_i, start_i, funct3_i,
// operand_a_i, operand_b_i, flush_i; busy_o, stall_o, done_o, result_o.
module muldiv_sequencer
   import riscv_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] operand_a_i,
   input  logic [XLEN-1:0] operand_b_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_PREP  = ST_PREP;
   localparam logic [2:0] S_CALC  = ST_CALC;
   localparam logic [2:0] S_FIXUP = ST_FIXUP;
   localparam logic [2:0] S_DONE  = ST_DONE;

   localparam int            CW       = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN-1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          special;
   logic          accept;

   assign accept = (state_q == S_IDLE) & start_i & ~flush_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept)
               state_d = S_PREP;
         end
         S_PREP: begin
            cnt_d   = '0;
            state_d = special ? S_DONE : S_CALC;
         end
         S_CALC: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST)
               state_d = S_FIXUP;
         end
         S_FIXUP: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort overrides every normal transition outside IDLE
      if (flush_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o  = (state_q != S_IDLE);
   assign done_o  = (state_q == S_DONE);
   // Released in DONE so the consumer advances while result_o is valid
   assign stall_o = accept | (state_q == S_PREP) |
                    (state_q == S_CALC) | (state_q == S_FIXUP);

   // Result loads are suppressed by flush so result_o keeps its old value
   muldiv_datapath u_dp (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (accept),
      .init_i       ((state_q == S_PREP) & ~flush_i),
      .step_i       ((state_q == S_CALC) & ~flush_i),
      .special_ld_i ((state_q == S_PREP) & special & ~flush_i),
      .fixup_i      ((state_q == S_FIXUP) & ~flush_i),
      .funct3_i     (funct3_i),
      .operand_a_i  (operand_a_i),
      .operand_b_i  (operand_b_i),
      .special_o    (special),
      .result_o     (result_o)
   );

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide instructions in the EX stage, beside the single-cycle ALU and its `alu_operator` control decode. It accepts one operation at a time and runs an iterative shift-add multiply or restoring divide over XLEN cycles. While it runs it holds the pipeline with a stall signal, then presents the result for one `done_o` cycle.

## Interface
- `XLEN`, 32, operand/result width; iteration count equals XLEN
- `clk_i` input 1 — single clock, rising edge
- `rst_i` input 1 — synchronous, active-high reset
- `start_i` input 1 — request; accepted only in IDLE
- `funct3_i` input 3 — M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `operand_a_i` input XLEN — rs1 value (multiplicand/dividend)
- `operand_b_i` input XLEN — rs2 value (multiplier/divisor)
- `flush_i` input 1 — abort in-flight op (branch mispredict/trap)
- `busy_o` output 1 — state != IDLE
- `stall_o` output 1 — combinational; hold pipeline
- `done_o` output 1 — one-cycle result-valid pulse
- `result_o` output XLEN — registered result

## Operation
- States: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE → PREP on `start_i & ~flush_i`.
  - Latch `funct3_i` and the operands.
  - Compute operand signs and magnitudes. Signed ops: DIV, REM, MULH (both operands); MULHSU (a only).
- PREP → DONE directly for divide special cases:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - Signed overflow (0x80000000 / −1): DIV → 0x80000000; REM → 0.
- PREP → CALC otherwise. Iteration counter reset to 0.
- CALC runs exactly XLEN cycles, one step per cycle, counter 0..XLEN−1:
  - Multiply: 2·XLEN product register, shift-add on magnitudes.
  - Divide: restoring; one quotient bit per cycle; remainder register is XLEN+1 bits.
- CALC → FIXUP when the counter reaches XLEN−1.
- FIXUP applies sign correction and selects the result:
  - Product negated if the operand signs differ (signed ops only).
  - MUL takes the low word; MULH/MULHSU/MULHU take the high word.
  - Quotient negated if the signs differ. Remainder takes the dividend's sign.
  - Result loaded into `result_o`.
- DONE: `done_o`=1 for this one cycle, then → IDLE unconditionally.
- `result_o` holds its value until the next result load; it is not cleared on IDLE.
- `start_i` is ignored in every state except IDLE, including DONE.
- Flush: `flush_i` in any non-IDLE state forces IDLE on the next edge.
  - No `done_o`; `result_o` unchanged.
  - `flush_i` with `start_i` in IDLE: the request is not accepted.
- Priority: `rst_i` > `flush_i` > normal transitions.

## Timing
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `result_o`=0, counter 0. `stall_o`=0 unless `start_i` is high.
- Reset mid-operation: all outputs return to the reset values on the next edge.
- With `start_i` accepted at edge N:
  - PREP in cycle N+1.
  - CALC in cycles N+2 … N+1+XLEN.
  - FIXUP in N+2+XLEN.
  - DONE (`done_o`, `result_o` valid) in N+3+XLEN, i.e. 35 cycles for XLEN=32.
- Special-case latency: DONE in cycle N+2.
- `stall_o` = (IDLE & `start_i` & ~`flush_i`) | (state ∈ {PREP, CALC, FIXUP}).
  - Deasserted in DONE, so the pipeline advances in the same cycle it consumes `result_o`.
- Back-to-back: the earliest next accept is the IDLE cycle after DONE, i.e. N+4+XLEN.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`
  - `muldiv_op_e` enum (funct3 encodings above)
  - `muldiv_state_e` enum (IDLE, PREP, CALC, FIXUP, DONE)
- One natural sub-module: `muldiv_datapath`.
  - Contains the product/remainder/quotient registers, the adder/subtractor and the negation logic.
  - Driven by step/load/fixup strobes from the FSM in `muldiv_sequencer`.

## Test plan
- MUL, a=7, b=0xFFFFFFFD, start at N → `done_o` only at N+35, `result_o`=0xFFFFFFEB; `stall_o` high N…N+34, low at N+35.
- a=b=0xFFFFFFFF: MULHU → 0xFFFFFFFE; MULH → 0x00000000; MULHSU → 0xFFFFFFFF; MUL → 0x00000001.
- a=0xFFFFFFF9 (−7), b=2: DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU → 0x7FFFFFFC; REMU → 0x00000001.
- Special cases, `done_o` at N+2:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 0x00000005.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0x00000000.
- Flush and start interactions:
  - `flush_i` in CALC cycle 10 → `busy_o`=0 next cycle, no `done_o`, `result_o` keeps its prior value.
  - `start_i` & `flush_i` together in IDLE → stays IDLE.
- Control robustness:
  - `start_i` held high across a whole op → second op accepted at N+36 (`busy_o` low for exactly one cycle, N+36).
  - `rst_i` mid-CALC → `busy_o`=0, `done_o`=0, `result_o`=0 on the next edge.
